// File: rtl/axis_upsize_p_if.sv
// Stream bundle for the width-up packer: narrow input beats on s_axis_*, packed words on m_axis_*.
// master = the surrounding logic (source and sink), slave = the packer itself.
interface axis_upsize_p_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 64,
    parameter int RATIO     = 4
);
    logic [WIDTH_IN-1:0]  s_axis_data;
    logic                 s_axis_valid;
    logic                 s_axis_last;
    logic                 s_axis_ready;
    logic [WIDTH_OUT-1:0] m_axis_data;
    logic                 m_axis_valid;
    logic                 m_axis_last;
    logic [RATIO-1:0]     m_axis_keep;
    logic                 m_axis_ready;

    modport master (
        output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, m_axis_keep
    );

    modport slave (
        input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last, m_axis_keep
    );
endinterface

// File: rtl/axis_upsize_p.sv
// Packs RATIO narrow beats into one WIDTH_OUT word (lane 0 first); a last beat closes the word early
// with upper lanes zeroed. Output is registered; only m_axis_ready reaches s_axis_ready combinationally.
module axis_upsize_p #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 64,
    parameter int RATIO     = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk_p,
    input  logic             rst_p,
    axis_upsize_p_if.slave   axis,
    output logic [CNT_W-1:0] word_count
);
    localparam int LANE_W = $clog2(RATIO);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

    logic [WIDTH_OUT-1:0] r_acc;
    logic [LANE_W-1:0]    r_lane;
    logic [RATIO-1:0]     r_kacc;
    logic                 r_run;
    logic [WIDTH_OUT-1:0] r_m_data;
    logic                 r_m_valid;
    logic                 r_m_last;
    logic [RATIO-1:0]     r_m_keep;
    logic [CNT_W-1:0]     r_word_count;

    logic                 w_s_ready;
    logic                 w_s_hs;
    logic                 w_m_hs;
    logic                 w_done;
    logic [WIDTH_OUT-1:0] w_merged_data;
    logic [RATIO-1:0]     w_merged_keep;

    // Input stalls whenever the output register is occupied and not draining this cycle.
    assign w_s_ready = r_run && (!r_m_valid || axis.m_axis_ready);
    assign w_s_hs    = axis.s_axis_valid && w_s_ready;
    assign w_m_hs    = r_m_valid && axis.m_axis_ready;
    assign w_done    = w_s_hs && ((r_lane == LANE_MAX) || axis.s_axis_last);

    always_comb begin
        w_merged_data = r_acc;
        w_merged_keep = r_kacc;
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) == r_lane) begin
                w_merged_data[i*WIDTH_IN +: WIDTH_IN] = axis.s_axis_data;
                w_merged_keep[i]                      = 1'b1;
            end else if (LANE_W'(i) > r_lane) begin
                w_merged_data[i*WIDTH_IN +: WIDTH_IN] = '0;
                w_merged_keep[i]                      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_p or negedge rst_p) begin
        if (!rst_p) begin
            r_run  <= 1'b0;
            r_acc  <= '0;
            r_kacc <= '0;
            r_lane <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_done) begin
                r_acc  <= '0;
                r_kacc <= '0;
                r_lane <= '0;
            end else if (w_s_hs) begin
                r_acc  <= w_merged_data;
                r_kacc <= w_merged_keep;
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    // A completion may coincide with the drain of the previous word, keeping valid high.
    always_ff @(posedge clk_p or negedge rst_p) begin
        if (!rst_p) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_keep  <= '0;
        end else if (w_done) begin
            r_m_data  <= w_merged_data;
            r_m_valid <= 1'b1;
            r_m_last  <= axis.s_axis_last;
            r_m_keep  <= w_merged_keep;
        end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_p or negedge rst_p) begin
        if (!rst_p) begin
            r_word_count <= '0;
        end else if (w_m_hs) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign axis.s_axis_ready = w_s_ready;
    assign axis.m_axis_data  = r_m_data;
    assign axis.m_axis_valid = r_m_valid;
    assign axis.m_axis_last  = r_m_last;
    assign axis.m_axis_keep  = r_m_keep;
    assign word_count        = r_word_count;
endmodule
